// File: rtl/link_mmio_port.sv
// link_mmio_port
//   Memory-mapped TX/RX port that sits between the processor data-memory port
//   and the data RAM. A 4-word window at BASE_ADDR is decoded locally. Every
//   other access passes straight through to the RAM.
//     +0 TX_DATA  W: push word toward the link        R: 0
//     +1 RX_DATA  W: pop RX head (data ignored)       R: RX head, 0 if empty
//     +2 STATUS   W: clear sticky error bits          R: status word
//     +3 reserved W: ignored                          R: 0
//   STATUS: [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty [7:4] rx_count
//           [11:8] tx_count [14] rx_underflow [15] tx_overflow
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   address_rw, data_in           processor address / store data
//   memory_write_enable           processor store strobe
//   data_out                      load data to processor (combinational)
//   ram_data_out                  read data from data RAM
//   ram_write_enable              store strobe to RAM, suppressed on window hits
//   link_tx_valid/data/ready      TX handshake toward the serializer
//   link_rx_valid/data/ready      RX handshake from the deserializer

// Single-clock FIFO with registered count. Full/empty come from the count
// at the start of the cycle, so a push on a full FIFO is never rescued by a
// pop in the same cycle; the caller decides legality before asserting push/pop.
module link_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);   // wraps modulo DEPTH
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Head reads as zero when empty so stale storage never leaks out.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

module link_mmio_port #(
    parameter logic [15:0] BASE_ADDR = 16'hFFFC,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address_rw,
    input  logic [15:0] data_in,
    input  logic        memory_write_enable,
    output logic [15:0] data_out,
    input  logic [15:0] ram_data_out,
    output logic        ram_write_enable,
    output logic        link_tx_valid,
    output logic [15:0] link_tx_data,
    input  logic        link_tx_ready,
    input  logic        link_rx_valid,
    input  logic [15:0] link_rx_data,
    output logic        link_rx_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          hit;
    logic [1:0]    offs;
    logic          win_wr;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [15:0]   tx_head, rx_head;

    logic          tx_ovf_set, rx_unf_set, sticky_clr;
    logic          tx_ovf_q, tx_ovf_d;
    logic          rx_unf_q, rx_unf_d;
    logic [15:0]   status;

    assign hit    = (address_rw[15:2] == BASE_ADDR[15:2]);
    assign offs   = address_rw[1:0];
    assign win_wr = memory_write_enable & hit;

    // Window stores are consumed here and never reach the RAM.
    assign ram_write_enable = memory_write_enable & ~hit;

    // Push/pop legality is judged only on registered full/empty, so nothing
    // here depends combinationally on link_tx_ready or link_rx_valid except
    // the FIFO update enables themselves.
    always_comb begin
        tx_push    = win_wr && (offs == 2'd0) && !tx_full;
        tx_ovf_set = win_wr && (offs == 2'd0) &&  tx_full;
        tx_pop     = !tx_empty && link_tx_ready;
        rx_push    = !rx_full && link_rx_valid;
        rx_pop     = win_wr && (offs == 2'd1) && !rx_empty;
        rx_unf_set = win_wr && (offs == 2'd1) &&  rx_empty;
        sticky_clr = win_wr && (offs == 2'd2);
    end

    // A set event in the same cycle as a clear leaves the bit set.
    always_comb begin
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~sticky_clr);
        rx_unf_d = rx_unf_set | (rx_unf_q & ~sticky_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    link_mmio_fifo #(.DEPTH(DEPTH), .W(16)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (data_in),
        .head  (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    link_mmio_fifo #(.DEPTH(DEPTH), .W(16)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (link_rx_data),
        .head  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign link_tx_valid = !tx_empty;
    assign link_tx_data  = tx_head;
    assign link_rx_ready = !rx_full;

    always_comb begin
        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[7:4]   = 4'(rx_count);
        status[11:8]  = 4'(tx_count);
        status[14]    = rx_unf_q;
        status[15]    = tx_ovf_q;
    end

    always_comb begin
        data_out = ram_data_out;
        if (hit) begin
            unique case (offs)
                2'd1:    data_out = rx_head;
                2'd2:    data_out = status;
                default: data_out = '0;
            endcase
        end
    end

endmodule
